// File: rtl/mmio_port_endpoint.sv
// rtl/mmio_port_endpoint.sv - MMIO port endpoint: host write strobe into RX FIFO, device word and status back to host
// Optional interrupt output enabled by defining MMIO_EP_IRQ_EN.
module mmio_port_endpoint #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  PORT_ID    = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_inform_write,
  input  logic [15:0] host_d_lo,
  input  logic [15:0] host_d_hi,
  input  logic        host_inform_read,
  output logic [15:0] host_rd_lo,
  output logic [15:0] host_rd_hi,
  output logic        dev_rx_valid,
  input  logic        dev_rx_ready,
  output logic [31:0] dev_rx_data,
  input  logic        dev_tx_valid,
  output logic        dev_tx_ready,
  input  logic [15:0] dev_tx_data
`ifdef MMIO_EP_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic          prev_w_q, prev_r_q;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   hold_q, hold_d;
  logic          tx_full_q, tx_full_d;
  logic          ovf_q, ovf_d;

  logic wr_ev, rd_ev, rx_full, pop, push, ovf_set, tx_load;
  logic [3:0] count4;

  always_comb begin
    wr_ev   = host_inform_write & ~prev_w_q;
    rd_ev   = host_inform_read & ~prev_r_q;
    rx_full = (count_q == CW'(FIFO_DEPTH));
    pop     = dev_rx_valid & dev_rx_ready;
    // A pop in the same cycle frees the slot, so a push onto a full FIFO still lands.
    push    = wr_ev & (~rx_full | pop);
    ovf_set = wr_ev & rx_full & ~pop;
    count_d = count_q + CW'(push) - CW'(pop);
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    tx_load = dev_tx_valid & ~tx_full_q;
    tx_full_d = tx_load | (tx_full_q & ~rd_ev);
    ovf_d   = ovf_set | (ovf_q & ~rd_ev);
    hold_d  = tx_load ? dev_tx_data : hold_q;
    count4  = '0;
    count4[CW-1:0] = count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_w_q  <= 1'b1;
      prev_r_q  <= 1'b1;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      hold_q    <= '0;
      tx_full_q <= 1'b0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      prev_w_q  <= host_inform_write;
      prev_r_q  <= host_inform_read;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      hold_q    <= hold_d;
      tx_full_q <= tx_full_d;
      ovf_q     <= ovf_d;
      if (push) mem_q[wptr_q] <= {host_d_hi, host_d_lo};
    end
  end

`ifdef MMIO_EP_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= tx_full_d | ovf_d;
  end
  assign irq = irq_q;
`endif

  assign dev_rx_valid = (count_q != '0);
  assign dev_rx_data  = mem_q[rptr_q];
  assign dev_tx_ready = ~tx_full_q;
  assign host_rd_lo   = hold_q;
  assign host_rd_hi   = {tx_full_q, ovf_q, rx_full, 1'b0, count4, PORT_ID};

endmodule

// File: tb/tb_mmio_port_endpoint.sv
// tb/tb_mmio_port_endpoint.sv - randomized and directed self-checking bench for mmio_port_endpoint
module tb_mmio_port_endpoint;
  localparam int         DEPTH = 4;
  localparam logic [7:0] PID   = 8'h5A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_inform_write = 1'b0;
  logic [15:0] host_d_lo = '0;
  logic [15:0] host_d_hi = '0;
  logic        host_inform_read = 1'b0;
  logic [15:0] host_rd_lo, host_rd_hi;
  logic        dev_rx_valid;
  logic        dev_rx_ready = 1'b0;
  logic [31:0] dev_rx_data;
  logic        dev_tx_valid = 1'b0;
  logic        dev_tx_ready;
  logic [15:0] dev_tx_data = '0;
`ifdef MMIO_EP_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  mmio_port_endpoint #(.FIFO_DEPTH(DEPTH), .PORT_ID(PID)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_inform_write(host_inform_write), .host_d_lo(host_d_lo), .host_d_hi(host_d_hi),
    .host_inform_read(host_inform_read),
    .host_rd_lo(host_rd_lo), .host_rd_hi(host_rd_hi),
    .dev_rx_valid(dev_rx_valid), .dev_rx_ready(dev_rx_ready), .dev_rx_data(dev_rx_data),
    .dev_tx_valid(dev_tx_valid), .dev_tx_ready(dev_tx_ready), .dev_tx_data(dev_tx_data)
`ifdef MMIO_EP_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a queue of host words, the TX word and two flags.
  logic [31:0] m_q[$];
  logic [15:0] m_hold;
  bit          m_tx_full, m_ovf, m_irq, m_pw, m_pr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_hold = '0; m_tx_full = 0; m_ovf = 0; m_irq = 0; m_pw = 1; m_pr = 1;
    end else begin
      bit wr, rd, pp, ld, of;
      wr = host_inform_write && !m_pw;
      rd = host_inform_read && !m_pr;
      pp = (m_q.size() != 0) && dev_rx_ready;
      ld = dev_tx_valid && !m_tx_full;
      of = 0;
      if (pp) void'(m_q.pop_front());
      if (wr) begin
        if (m_q.size() < DEPTH) m_q.push_back({host_d_hi, host_d_lo});
        else of = 1;
      end
      if (rd) begin m_ovf = 0; m_tx_full = 0; end
      if (of) m_ovf = 1;
      if (ld) begin m_tx_full = 1; m_hold = dev_tx_data; end
      m_irq = m_tx_full || m_ovf;
      m_pw = host_inform_write;
      m_pr = host_inform_read;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_status();
    logic [3:0] c;
    c = 4'(m_q.size());
    return {m_tx_full, m_ovf, (m_q.size() == DEPTH), 1'b0, c, PID};
  endfunction

  always @(negedge clk) begin
    chk("rx_valid", 32'(dev_rx_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) chk("rx_data", dev_rx_data, m_q[0]);
    chk("tx_ready", 32'(dev_tx_ready), 32'(!m_tx_full));
    chk("rd_lo", 32'(host_rd_lo), 32'(m_hold));
    chk("rd_hi", 32'(host_rd_hi), 32'(m_status()));
`ifdef MMIO_EP_IRQ_EN
    chk("irq", 32'(irq), 32'(m_irq));
`endif
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wpulse(input logic [15:0] hi, input logic [15:0] lo);
    host_d_hi = hi; host_d_lo = lo; host_inform_write = 1'b1;
    cyc(1);
    host_inform_write = 1'b0;
    cyc(1);
  endtask

  task automatic rpulse();
    host_inform_read = 1'b1; cyc(1);
    host_inform_read = 1'b0; cyc(1);
  endtask

  task automatic reset_literals(input string tag);
    chk({tag, "_tx_ready"}, 32'(dev_tx_ready), 32'h1);
    chk({tag, "_rx_valid"}, 32'(dev_rx_valid), 32'h0);
    chk({tag, "_rx_data"}, dev_rx_data, 32'h0);
    chk({tag, "_rd_lo"}, 32'(host_rd_lo), 32'h0);
    chk({tag, "_rd_hi"}, 32'(host_rd_hi), 32'h005A);
`ifdef MMIO_EP_IRQ_EN
    chk({tag, "_irq"}, 32'(irq), 32'h0);
`endif
  endtask

  initial begin
    cyc(3);
    reset_literals("reset");
    rst_n = 1'b1;
    cyc(2);

    // Single write, then strobe held high must not re-trigger.
    host_d_hi = 16'h1234; host_d_lo = 16'hABCD; host_inform_write = 1'b1;
    cyc(1);
    chk("wr1_valid", 32'(dev_rx_valid), 32'h1);
    chk("wr1_data", dev_rx_data, 32'h1234ABCD);
    chk("wr1_status", 32'(host_rd_hi), 32'h015A);
    cyc(5);
    chk("wr_hold_status", 32'(host_rd_hi), 32'h015A);
    host_inform_write = 1'b0;
    dev_rx_ready = 1'b1; cyc(1); dev_rx_ready = 1'b0;
    cyc(1);

    // Overflow: five writes into a four-deep FIFO.
    for (int i = 1; i <= 5; i++) wpulse(16'h0, 16'(i));
    chk("ovf_status", 32'(host_rd_hi), 32'h645A);
    dev_rx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", dev_rx_data, 32'(i));
      cyc(1);
    end
    dev_rx_ready = 1'b0;
    chk("drained_valid", 32'(dev_rx_valid), 32'h0);
    chk("drained_status", 32'(host_rd_hi), 32'h405A);
    rpulse();
    chk("ovf_cleared", 32'(host_rd_hi), 32'h005A);

    // Full FIFO: simultaneous push and pop keeps count, no overflow.
    for (int i = 11; i <= 14; i++) wpulse(16'h0, 16'(i));
    chk("full_status", 32'(host_rd_hi), 32'h245A);
    host_d_lo = 16'd15; host_d_hi = 16'h0; host_inform_write = 1'b1; dev_rx_ready = 1'b1;
    cyc(1);
    host_inform_write = 1'b0; dev_rx_ready = 1'b0;
    chk("pushpop_status", 32'(host_rd_hi), 32'h245A);
    chk("pushpop_head", dev_rx_data, 32'd12);
    dev_rx_ready = 1'b1; cyc(3);
    chk("pushpop_tail", dev_rx_data, 32'd15);
    cyc(1); dev_rx_ready = 1'b0;

    // TX holding register and read-strobe release.
    dev_tx_valid = 1'b1; dev_tx_data = 16'hBEEF;
    cyc(1);
    dev_tx_data = 16'hCAFE;
    chk("tx_lo", 32'(host_rd_lo), 32'hBEEF);
    chk("tx_hi", 32'(host_rd_hi), 32'h805A);
`ifdef MMIO_EP_IRQ_EN
    chk("irq_set", 32'(irq), 32'h1);
`endif
    cyc(1);
    chk("tx_stall_ready", 32'(dev_tx_ready), 32'h0);
    chk("tx_stall_lo", 32'(host_rd_lo), 32'hBEEF);
    host_inform_read = 1'b1;
    cyc(1);
    host_inform_read = 1'b0;
    chk("tx_released", 32'(dev_tx_ready), 32'h1);
`ifdef MMIO_EP_IRQ_EN
    chk("irq_clear", 32'(irq), 32'h0);
`endif
    cyc(1);
    dev_tx_valid = 1'b0;
    chk("tx_second", 32'(host_rd_lo), 32'hCAFE);
    rpulse();

    // Randomized traffic with occasional asynchronous reset.
    for (int n = 0; n < 3000; n++) begin
      host_inform_write = 1'($urandom_range(0, 2) == 0);
      host_inform_read  = 1'($urandom_range(0, 3) == 0);
      host_d_hi   = 16'($urandom);
      host_d_lo   = 16'($urandom);
      dev_rx_ready = 1'($urandom_range(0, 3) == 0);
      dev_tx_valid = 1'($urandom_range(0, 1));
      dev_tx_data  = 16'($urandom);
      if (n % 700 == 350) begin
        #2 rst_n = 1'b0;
        #1 reset_literals("async_rst");
        cyc(1);
        rst_n = 1'b1;
      end else begin
        cyc(1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
